fpu_bus_slave: RTL and testbench

Bus-side responder for the FPU: decodes the 8-bit host bus (`cs`/`rd`/`wr`/`addr`), assembles 32-bit operands A and B from byte writes, holds the operation code and issues a start pulse to the FPU core. It captures the core result, serves it back as four byte reads and runs the `cmd_end`/`end_ack` completion handshake. It sits between the system bus and the FPU arithmetic core.

---
 rtl/fpu_bus_slave_pkg.sv | 38 +++
 rtl/fpu_bus_slave.sv | 126 ++++++++++++
 tb/tb_fpu_bus_slave.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_bus_slave_pkg.sv
// Shared FPU definitions: operation codes, host bus address map and the
// bus responder state encoding.
package pa_fpu;

    typedef enum logic [3:0] {
        op_add  = 4'h0,
        op_sub  = 4'h1,
        op_mul  = 4'h2,
        op_div  = 4'h3,
        op_sqrt = 4'h4,
        op_abs  = 4'h5,
        op_neg  = 4'h6,
        op_cmp  = 4'h7
    } e_fpu_operations;

    localparam logic [3:0] FPU_A0     = 4'h0;
    localparam logic [3:0] FPU_A1     = 4'h1;
    localparam logic [3:0] FPU_A2     = 4'h2;
    localparam logic [3:0] FPU_A3     = 4'h3;
    localparam logic [3:0] FPU_B0     = 4'h4;
    localparam logic [3:0] FPU_B1     = 4'h5;
    localparam logic [3:0] FPU_B2     = 4'h6;
    localparam logic [3:0] FPU_B3     = 4'h7;
    localparam logic [3:0] FPU_OP     = 4'h8;
    localparam logic [3:0] FPU_START  = 4'h9;
    localparam logic [3:0] FPU_RES0   = 4'h9;
    localparam logic [3:0] FPU_RES1   = 4'hA;
    localparam logic [3:0] FPU_RES2   = 4'hB;
    localparam logic [3:0] FPU_RES3   = 4'hC;
    localparam logic [3:0] FPU_STATUS = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } e_fpu_bus_state;

endpackage

// File: rtl/fpu_bus_slave.sv
// Host bus responder for the FPU core: operand/op registers, start pulse,
// result capture and cmd_end/end_ack completion handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for host; operand/op writes accepted, 0x9 starts core
// ST_RUN  | core busy; register writes locked out, waiting for core_done
// ST_DONE | result captured, cmd_end high until host raises end_ack
module fpu_bus_slave
    import pa_fpu::*;
(
    input  logic        clk,
    input  logic        arst,
    input  logic [7:0]  databus_in,
    output logic [7:0]  databus_out,
    input  logic [3:0]  addr,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic        end_ack,
    output logic        cmd_end,
    output logic        busy,
    output logic [3:0]  core_op,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic        core_start,
    input  logic [31:0] core_result,
    input  logic        core_done
);

    e_fpu_bus_state state;
    logic [31:0]    a_reg;
    logic [31:0]    b_reg;
    logic [31:0]    res_reg;
    logic [3:0]     op_reg;
    logic           wr_prev;
    logic           wr_commit;
    logic [7:0]     rd_data;

    // A held-low strobe commits once: only the cycle where wr has just fallen.
    assign wr_commit = !cs && !wr && wr_prev;

    assign core_a  = a_reg;
    assign core_b  = b_reg;
    assign core_op = op_reg;

    // Read data selection from the current register contents.
    always_comb begin
        rd_data = 8'h00;
        case (addr)
            FPU_A0, FPU_A1, FPU_A2, FPU_A3: rd_data = a_reg[{addr[1:0], 3'b000} +: 8];
            FPU_B0, FPU_B1, FPU_B2, FPU_B3: rd_data = b_reg[{addr[1:0], 3'b000} +: 8];
            FPU_OP:     rd_data = {4'h0, op_reg};
            FPU_RES0:   rd_data = res_reg[7:0];
            FPU_RES1:   rd_data = res_reg[15:8];
            FPU_RES2:   rd_data = res_reg[23:16];
            FPU_RES3:   rd_data = res_reg[31:24];
            FPU_STATUS: rd_data = {6'b0, cmd_end, busy};
            default:    rd_data = 8'h00;
        endcase
    end

    // Strobe history and registered read port (one cycle read latency).
    always_ff @(posedge clk) begin
        if (!arst) begin
            wr_prev     <= 1'b1;
            databus_out <= 8'h00;
        end else begin
            wr_prev     <= wr;
            databus_out <= (!cs && !rd) ? rd_data : 8'h00;
        end
    end

    // Sequencing FSM with operand/op/result registers and registered flags.
    always_ff @(posedge clk) begin
        if (!arst) begin
            state      <= ST_IDLE;
            a_reg      <= 32'h0;
            b_reg      <= 32'h0;
            res_reg    <= 32'h0;
            op_reg     <= 4'h0;
            busy       <= 1'b0;
            cmd_end    <= 1'b0;
            core_start <= 1'b0;
        end else begin
            core_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (wr_commit) begin
                        case (addr)
                            FPU_A0, FPU_A1, FPU_A2, FPU_A3:
                                a_reg[{addr[1:0], 3'b000} +: 8] <= databus_in;
                            FPU_B0, FPU_B1, FPU_B2, FPU_B3:
                                b_reg[{addr[1:0], 3'b000} +: 8] <= databus_in;
                            FPU_OP:
                                op_reg <= databus_in[3:0];
                            FPU_START: begin
                                state      <= ST_RUN;
                                core_start <= 1'b1;
                                busy       <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (core_done) begin
                        state   <= ST_DONE;
                        res_reg <= core_result;
                        busy    <= 1'b0;
                        cmd_end <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // A start strobe coinciding with the ack is deliberately dropped.
                    if (end_ack) begin
                        state   <= ST_IDLE;
                        cmd_end <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_bus_slave.sv
// Self-checking bench for fpu_bus_slave: directed scenarios plus a random
// transaction mix checked against a transaction-level model.
module tb_fpu_bus_slave;
    import pa_fpu::*;

    logic        clk = 1'b0;
    logic        arst = 1'b0;
    logic [7:0]  databus_in = 8'h00;
    logic [7:0]  databus_out;
    logic [3:0]  addr = 4'h0;
    logic        cs = 1'b1;
    logic        rd = 1'b1;
    logic        wr = 1'b1;
    logic        end_ack = 1'b0;
    logic        cmd_end;
    logic        busy;
    logic [3:0]  core_op;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_start;
    logic [31:0] core_result = 32'h0;
    logic        core_done = 1'b0;

    int checks = 0;
    int failures = 0;
    int starts = 0;
    int busy_cycles = 0;

    // reference model: register words, phase 0 idle / 1 running / 2 done
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;
    int          m_phase;
    int          m_starts;

    fpu_bus_slave dut (
        .clk(clk), .arst(arst), .databus_in(databus_in), .databus_out(databus_out),
        .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(cmd_end),
        .busy(busy), .core_op(core_op), .core_a(core_a), .core_b(core_b),
        .core_start(core_start), .core_result(core_result), .core_done(core_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_start === 1'b1) starts++;
        if (busy === 1'b1) busy_cycles++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] put_byte(input logic [31:0] w, input int k, input logic [7:0] d);
        logic [31:0] mask;
        mask = 32'hFF << (8 * k);
        return (w & ~mask) | ({24'h0, d} << (8 * k));
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input int k);
        logic [31:0] s;
        s = w >> (8 * k);
        return s[7:0];
    endfunction

    function automatic logic [7:0] m_read(input logic [3:0] a);
        int ai;
        ai = int'(a);
        if (ai <= 3) return get_byte(m_a, ai);
        if (ai <= 7) return get_byte(m_b, ai - 4);
        if (ai == 8) return {4'h0, m_op};
        if (ai <= 12) return get_byte(m_res, ai - 9);
        if (ai == 13) return {6'b0, m_phase == 2, m_phase == 1};
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_a = 32'h0; m_b = 32'h0; m_res = 32'h0; m_op = 4'h0; m_phase = 0;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_a"}, core_a, m_a);
        check_val({tag, "_b"}, core_b, m_b);
        check_val({tag, "_op"}, 32'(core_op), 32'(m_op));
        check_val({tag, "_busy"}, 32'(busy), 32'(m_phase == 1));
        check_val({tag, "_cmd_end"}, 32'(cmd_end), 32'(m_phase == 2));
        check_val({tag, "_starts"}, 32'(starts), 32'(m_starts));
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
        addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
        @(negedge clk);
        cs = 1'b1; wr = 1'b1;
        @(negedge clk);
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
        addr = a; cs = 1'b0; rd = 1'b0;
        @(negedge clk);
        d = databus_out;
        cs = 1'b1; rd = 1'b1;
        @(negedge clk);
        check_val("bus_idle", 32'(databus_out), 32'h0);
    endtask

    task automatic act_write(input logic [3:0] a, input logic [7:0] d);
        bus_write(a, d);
        if (m_phase == 0) begin
            if (a <= 4'h3) m_a = put_byte(m_a, int'(a), d);
            else if (a <= 4'h7) m_b = put_byte(m_b, int'(a) - 4, d);
            else if (a == 4'h8) m_op = d[3:0];
            else if (a == 4'h9) begin m_phase = 1; m_starts++; end
        end
    endtask

    task automatic act_read(input logic [3:0] a);
        logic [7:0] got;
        bus_read(a, got);
        check_val("read", 32'(got), 32'(m_read(a)));
    endtask

    task automatic act_done(input logic [31:0] res);
        core_result = res; core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        if (m_phase == 1) begin m_phase = 2; m_res = res; end
    endtask

    task automatic act_ack();
        end_ack = 1'b1;
        @(negedge clk);
        end_ack = 1'b0;
        if (m_phase == 2) m_phase = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] got;
        logic [7:0] exp_bytes [8];
        logic [7:0] res_bytes [4];
        exp_bytes = '{8'hDA, 8'h0F, 8'h49, 8'h40, 8'h54, 8'hF8, 8'h2D, 8'h40};
        res_bytes = '{8'hBE, 8'hC7, 8'h7B, 8'h44};
        m_starts = 0;
        model_reset();

        // reset held for two edges
        @(negedge clk);
        @(negedge clk);
        check_val("rst_dbout", 32'(databus_out), 32'h0);
        check_state("rst");
        arst = 1'b1;
        @(negedge clk);
        bus_read(FPU_STATUS, got);
        check_val("rst_status", 32'(got), 32'h0);

        // operand load and readback
        for (int i = 0; i < 4; i++) act_write(4'(i), get_byte(32'h40490FDA, i));
        for (int i = 0; i < 4; i++) act_write(4'(i + 4), get_byte(32'h402DF854, i));
        check_val("load_a", core_a, 32'h40490FDA);
        check_val("load_b", core_b, 32'h402DF854);
        for (int i = 0; i < 8; i++) begin
            bus_read(4'(i), got);
            check_val("readback", 32'(got), 32'(exp_bytes[i]));
        end

        // full operation, 20 cycle core latency
        act_write(FPU_OP, 8'(op_div));
        check_val("op_div", 32'(core_op), 32'(op_div));
        busy_cycles = 0;
        act_write(FPU_START, 8'hA5);
        check_state("run");
        repeat (18) @(negedge clk);
        act_done(32'h447BC7BE);
        check_val("busy_len", 32'(busy_cycles), 32'd20);
        check_val("one_start", 32'(starts), 32'd1);
        check_state("done");
        for (int i = 0; i < 4; i++) begin
            bus_read(4'(i + 9), got);
            check_val("result", 32'(got), 32'(res_bytes[i]));
        end
        end_ack = 1'b1;
        check_val("ack_hold", 32'(cmd_end), 32'd1);
        @(negedge clk);
        end_ack = 1'b0;
        check_val("ack_clear", 32'(cmd_end), 32'd0);
        m_phase = 0;

        // lockout while running
        act_write(FPU_START, 8'h00);
        act_write(FPU_A0, 8'h11);
        act_write(FPU_START, 8'h00);
        check_state("lockout");
        act_done(32'h3F800000);
        act_write(FPU_A0, 8'h22);
        check_state("lockout_done");
        act_ack();
        check_state("lockout_ack");

        // long write strobe on start
        addr = FPU_START; cs = 1'b0; wr = 1'b0;
        repeat (5) @(negedge clk);
        cs = 1'b1; wr = 1'b1;
        @(negedge clk);
        m_phase = 1; m_starts++;
        check_state("long_strobe");
        act_done(32'h12345678);
        act_ack();

        // ack and start together in DONE: start is lost
        act_write(FPU_START, 8'h00);
        act_done(32'hCAFEF00D);
        end_ack = 1'b1; addr = FPU_START; cs = 1'b0; wr = 1'b0;
        @(negedge clk);
        end_ack = 1'b0; cs = 1'b1; wr = 1'b1;
        @(negedge clk);
        m_phase = 0;
        check_state("ack_start");

        // reset mid-operation, then a stale core_done
        act_write(FPU_START, 8'h00);
        arst = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        model_reset();
        act_done(32'hDEADBEEF);
        check_state("midrst");
        for (int i = 9; i <= 13; i++) act_read(4'(i));

        // random transaction mix
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 3) act_write(4'($urandom_range(0, 15)), 8'($urandom));
            else if (r <= 6) act_read(4'($urandom_range(0, 15)));
            else if (r == 7) act_done($urandom);
            else if (r == 8) act_ack();
            else begin
                @(negedge clk);
                check_val("idle_dbout", 32'(databus_out), 32'h0);
            end
            check_state("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
